// File: rtl/tube_scan.sv
// tube_scan: eight-digit time-multiplexed display scanner with single-digit write,
// whole-display load and digit-enable mask. Define TUBE_BLANK_EN for inter-digit blanking.
module tube_scan #(
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [4:0]  wr_data,
    input  logic        ld_en,
    input  logic [31:0] ld_hex,
    input  logic        mask_we,
    input  logic [7:0]  mask_data,
    output logic [4:0]  num,
    output logic [7:0]  dig_n,
    output logic        scan_wrap
);

    // Counter is sized for the slot length; BLANK < DIV so it never widens it.
    localparam int CW = $clog2((DIV > BLANK) ? DIV : BLANK + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          tick;
    logic [4:0]    digit_buf [8];
    logic [7:0]    mask;
    logic [7:0]    sel_n;
    logic          wrap_pend;

    assign tick = (cnt == CNT_MAX);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                idx <= idx + 3'd1;
            end
        end
    end

    // NOTE: the buffer is only eight small registers, so it is reset like any flop rather than left as RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                digit_buf[k] <= '0;
            end
            mask <= 8'hFF;
        end else begin
            if (ld_en) begin
                for (int k = 0; k < 8; k++) begin
                    digit_buf[k] <= {1'b0, ld_hex[4*k +: 4]};
                end
            end
            // NOTE: the later non-blocking write wins, so a single-digit write overrides the load.
            if (wr_en) begin
                digit_buf[wr_addr] <= wr_data;
            end
            if (mask_we) begin
                mask <= mask_data;
            end
        end
    end

    // NOTE: every path assigns sel_n after its default, so no latch is inferred.
    always_comb begin
        sel_n = 8'hFF;
        if (mask[idx]) begin
            sel_n = ~(8'h01 << idx);
        end
`ifdef TUBE_BLANK_EN
        if (cnt < CW'(BLANK)) begin
            sel_n = 8'hFF;
        end
`endif
    end

    // Outputs lag idx/cnt by one cycle; scan_wrap is delayed once more to line up with digit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num       <= '0;
            dig_n     <= 8'hFF;
            wrap_pend <= 1'b0;
            scan_wrap <= 1'b0;
        end else begin
            num       <= digit_buf[idx];
            dig_n     <= sel_n;
            wrap_pend <= tick && (idx == 3'd7);
            scan_wrap <= wrap_pend;
        end
    end

endmodule
